// File: rtl/rpm_pkg.sv
// Shared constants for the spinner rate stage: FSM state encodings, default
// ramp settings and the half-period constant used by the phase accumulator.
package rpm_pkg;

    localparam int RPM_MAX_DEFAULT  = 200;
    localparam int RAMP_DIV_DEFAULT = 5_000_000;

    typedef logic [1:0] rpm_state_t;

    localparam rpm_state_t IDLE      = 2'd0;
    localparam rpm_state_t RAMP_UP   = 2'd1;
    localparam rpm_state_t CRUISE    = 2'd2;
    localparam rpm_state_t RAMP_DOWN = 2'd3;

    // Accumulator units per clk_step half period: one RPM unit added per clock.
    function automatic longint unsigned rpm_half(input longint unsigned clk_hz,
                                                 input longint unsigned steps_per_rev);
        return (clk_hz * 64'd60) / (64'd2 * steps_per_rev);
    endfunction

endpackage

// File: rtl/rpm_phase_acc.sv
// Fractional phase accumulator turning an RPM value into a 50% duty step clock
// plus a one-cycle pulse on each rising edge of that clock.
module rpm_phase_acc #(
    parameter int              ACC_W = 28,
    parameter longint unsigned HALF  = 125_000_000
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic [7:0] rpm,
    output logic       clk_step,
    output logic       step_tick
);

    localparam logic [ACC_W-1:0] HALF_W = ACC_W'(HALF);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_next;
    logic             toggle;
    logic             clk_step_reg;
    logic             step_tick_reg;

    // The remainder after subtracting HALF is kept so the average rate is exact;
    // with rpm == 0 the sum never reaches HALF and the phase simply holds.
    always_comb begin
        acc_sum  = acc_reg + ACC_W'(rpm);
        toggle   = (acc_sum >= HALF_W);
        acc_next = toggle ? (acc_sum - HALF_W) : acc_sum;
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            acc_reg       <= '0;
            clk_step_reg  <= 1'b0;
            step_tick_reg <= 1'b0;
        end else begin
            acc_reg       <= acc_next;
            clk_step_reg  <= clk_step_reg ^ toggle;
            step_tick_reg <= toggle & ~clk_step_reg;
        end
    end

    assign clk_step  = clk_step_reg;
    assign step_tick = step_tick_reg;

endmodule

// File: rtl/rpm_step_generator.sv
// Slew-limited RPM ramp feeding a phase accumulator that clocks the 12-step
// spinner. Define RPM_BCD_EN to add the rpm_bcd display output.
module rpm_step_generator
    import rpm_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int STEPS_PER_REV = 12,
    parameter int RPM_MAX       = RPM_MAX_DEFAULT,
    parameter int RAMP_DIV      = RAMP_DIV_DEFAULT,
    parameter int ACC_W         = 28
) (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  rpm_target,
    output logic        clk_step,
    output logic        step_tick,
    output logic [7:0]  rpm_current,
    output logic        at_speed
`ifdef RPM_BCD_EN
    ,
    output logic [11:0] rpm_bcd
`endif
);

    localparam longint unsigned HALF    = rpm_half(64'(CLK_HZ), 64'(STEPS_PER_REV));
    localparam logic [7:0]      RPM_CAP = 8'(RPM_MAX);
    localparam int              RC_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [7:0]      tgt_next;
    logic [7:0]      tgt_reg;
    logic [RC_W-1:0] ramp_cnt_reg;
    logic            ramp_tick;
    rpm_state_t      state_reg;
    rpm_state_t      state_next;
    logic [7:0]      rpm_reg;
    logic [7:0]      rpm_next;

    always_comb begin
        tgt_next = 8'd0;
        if (enable) begin
            tgt_next = (rpm_target > RPM_CAP) ? RPM_CAP : rpm_target;
        end
    end

    assign ramp_tick = (ramp_cnt_reg == RC_W'(RAMP_DIV - 1));

    // Direction is re-decided from tgt on every tick, so a target change during
    // a ramp reverses or stops it on the very next step.
    always_comb begin
        state_next = state_reg;
        rpm_next   = rpm_reg;
        if (ramp_tick) begin
            if (tgt_reg > rpm_reg) begin
                rpm_next   = rpm_reg + 8'd1;
                state_next = (rpm_next == tgt_reg) ? CRUISE : RAMP_UP;
            end else if (tgt_reg < rpm_reg) begin
                rpm_next = rpm_reg - 8'd1;
                if (rpm_next == tgt_reg) begin
                    state_next = (tgt_reg == 8'd0) ? IDLE : CRUISE;
                end else begin
                    state_next = RAMP_DOWN;
                end
            end else begin
                state_next = (rpm_reg == 8'd0) ? IDLE : CRUISE;
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            tgt_reg      <= 8'd0;
            ramp_cnt_reg <= '0;
            state_reg    <= IDLE;
            rpm_reg      <= 8'd0;
        end else begin
            tgt_reg      <= tgt_next;
            ramp_cnt_reg <= ramp_tick ? '0 : ramp_cnt_reg + 1'b1;
            state_reg    <= state_next;
            rpm_reg      <= rpm_next;
        end
    end

    assign rpm_current = rpm_reg;
    assign at_speed    = (state_reg == CRUISE);

    rpm_phase_acc #(
        .ACC_W (ACC_W),
        .HALF  (HALF)
    ) u_phase_acc (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .rpm       (rpm_reg),
        .clk_step  (clk_step),
        .step_tick (step_tick)
    );

`ifdef RPM_BCD_EN
    logic [19:0] bcd_shift;
    logic [11:0] rpm_bcd_reg;

    // Double dabble: hundreds/tens/ones live in [19:8], binary shifts out of [7:0].
    always_comb begin
        bcd_shift      = 20'd0;
        bcd_shift[7:0] = rpm_reg;
        for (int i = 0; i < 8; i++) begin
            if (bcd_shift[11:8] >= 4'd5)  bcd_shift[11:8]  = bcd_shift[11:8] + 4'd3;
            if (bcd_shift[15:12] >= 4'd5) bcd_shift[15:12] = bcd_shift[15:12] + 4'd3;
            if (bcd_shift[19:16] >= 4'd5) bcd_shift[19:16] = bcd_shift[19:16] + 4'd3;
            bcd_shift = bcd_shift << 1;
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            rpm_bcd_reg <= 12'h000;
        end else begin
            rpm_bcd_reg <= bcd_shift[19:8];
        end
    end

    assign rpm_bcd = rpm_bcd_reg;
`endif

endmodule

// File: tb/tb_rpm_step_generator.sv
// Directed bench for rpm_step_generator with CLK_HZ=1200, RAMP_DIV=4 (HALF=3000).
module tb_rpm_step_generator;

    logic       clk_50MHz = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] rpm_target = 8'd0;
    logic       clk_step;
    logic       step_tick;
    logic [7:0] rpm_current;
    logic       at_speed;
`ifdef RPM_BCD_EN
    logic [11:0] rpm_bcd;
`endif

    int errors = 0;
    int checks = 0;

    rpm_step_generator #(
        .CLK_HZ   (1200),
        .RAMP_DIV (4)
    ) dut (
        .clk_50MHz   (clk_50MHz),
        .rst         (rst),
        .enable      (enable),
        .rpm_target  (rpm_target),
        .clk_step    (clk_step),
        .step_tick   (step_tick),
        .rpm_current (rpm_current),
        .at_speed    (at_speed)
`ifdef RPM_BCD_EN
        ,
        .rpm_bcd     (rpm_bcd)
`endif
    );

    always #5 clk_50MHz = ~clk_50MHz;

    typedef struct {
        logic       en;
        logic [7:0] tgt;
        int         wait_cyc;
        logic [7:0] exp_rpm;
        logic       exp_at;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    // Reset is released on a falling edge, so the next rising edge is edge 1.
    task automatic start(input logic en, input logic [7:0] tgt);
        rst        = 1'b1;
        enable     = en;
        rpm_target = tgt;
        cycles(3);
        rst = 1'b0;
    endtask

    initial begin
        int  n;
        int  high;
        int  ticks;
        int  changes;
        bit  found;
        logic v;

        // Edge numbers in comments count rising edges after reset release.
        vecs[0]  = '{1'b1, 8'd60,  239, 8'd59,  1'b0}; // E239
        vecs[1]  = '{1'b1, 8'd60,  1,   8'd60,  1'b1}; // E240 reaches 60
        vecs[2]  = '{1'b1, 8'd60,  40,  8'd60,  1'b1}; // E280 cruise holds
        vecs[3]  = '{1'b1, 8'd255, 4,   8'd61,  1'b0}; // E284 clamp -> ramp up
        vecs[4]  = '{1'b1, 8'd255, 555, 8'd199, 1'b0}; // E839
        vecs[5]  = '{1'b1, 8'd255, 1,   8'd200, 1'b1}; // E840 clamped at 200
        vecs[6]  = '{1'b1, 8'd60,  4,   8'd199, 1'b0}; // E844 ramp down
        vecs[7]  = '{1'b1, 8'd60,  555, 8'd61,  1'b0}; // E1399
        vecs[8]  = '{1'b1, 8'd60,  1,   8'd60,  1'b1}; // E1400 cruise 60
        vecs[9]  = '{1'b0, 8'd60,  4,   8'd59,  1'b0}; // E1404 enable dropped
        vecs[10] = '{1'b0, 8'd60,  3,   8'd59,  1'b0}; // E1407 between ticks
        vecs[11] = '{1'b0, 8'd60,  1,   8'd58,  1'b0}; // E1408
        vecs[12] = '{1'b0, 8'd60,  231, 8'd1,   1'b0}; // E1639
        vecs[13] = '{1'b0, 8'd60,  1,   8'd0,   1'b0}; // E1640 idle
        vecs[14] = '{1'b0, 8'd60,  40,  8'd0,   1'b0}; // E1680 stays idle
        vecs[15] = '{1'b1, 8'd60,  160, 8'd40,  1'b0}; // E1840 ramping up
        vecs[16] = '{1'b1, 8'd30,  4,   8'd39,  1'b0}; // E1844 reverses
        vecs[17] = '{1'b1, 8'd30,  35,  8'd31,  1'b0}; // E1879
        vecs[18] = '{1'b1, 8'd30,  1,   8'd30,  1'b1}; // E1880 cruise 30

        // Reset held with a live request: everything stays at zero.
        rst        = 1'b1;
        enable     = 1'b1;
        rpm_target = 8'd60;
        cycles(3);
        check("rst_rpm", rpm_current, 0);
        check("rst_at_speed", at_speed, 0);
        check("rst_clk_step", clk_step, 0);
        check("rst_step_tick", step_tick, 0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            enable     = vecs[i].en;
            rpm_target = vecs[i].tgt;
            cycles(vecs[i].wait_cyc);
            check($sformatf("vec%0d_rpm", i), rpm_current, vecs[i].exp_rpm);
            check($sformatf("vec%0d_at_speed", i), at_speed, vecs[i].exp_at);
        end

        // Cruise at 60 RPM: 100-cycle period, 50/50 duty, 12 ticks per 1200 cycles.
        start(1'b1, 8'd60);
        cycles(240);
        check("cruise_rpm", rpm_current, 60);
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            cycles(1);
            if (step_tick) begin
                found = 1'b1;
                break;
            end
        end
        check("cruise_tick_seen", found, 1);
        check("cruise_tick_on_rise", clk_step, 1);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            cycles(1);
            if (step_tick) begin
                n = k;
                break;
            end
        end
        check("cruise_period", n, 100);
        high = 0;
        for (int k = 0; k < 100; k++) begin
            cycles(1);
            high += int'(clk_step);
        end
        check("cruise_high_cycles", high, 50);
        ticks = 0;
        for (int k = 0; k < 1200; k++) begin
            cycles(1);
            ticks += int'(step_tick);
        end
        check("cruise_ticks_1200", ticks, 12);

        // Ramp to zero freezes the step clock; restarting resumes stepping.
        start(1'b1, 8'd60);
        cycles(240);
        enable = 1'b0;
        cycles(250);
        check("freeze_rpm", rpm_current, 0);
        v       = clk_step;
        changes = 0;
        ticks   = 0;
        for (int k = 0; k < 300; k++) begin
            cycles(1);
            if (clk_step !== v) changes++;
            ticks += int'(step_tick);
        end
        check("freeze_clk_changes", changes, 0);
        check("freeze_ticks", ticks, 0);
        enable = 1'b1;
        found  = 1'b0;
        for (int k = 0; k < 600; k++) begin
            cycles(1);
            if (step_tick) begin
                found = 1'b1;
                break;
            end
        end
        check("restart_tick_seen", found, 1);

        // Asynchronous reset between clock edges mid-cruise.
        start(1'b1, 8'd60);
        cycles(260);
        check("areset_pre_rpm", rpm_current, 60);
        check("areset_pre_at_speed", at_speed, 1);
        #2 rst = 1'b1;
        #1;
        check("areset_rpm", rpm_current, 0);
        check("areset_at_speed", at_speed, 0);
        check("areset_clk_step", clk_step, 0);
        check("areset_step_tick", step_tick, 0);
        @(negedge clk_50MHz);
        rst = 1'b0;
        cycles(3);
        check("areset_restart_e3", rpm_current, 0);
        cycles(1);
        check("areset_restart_e4", rpm_current, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
